// File: rtl/perf_event_counters.sv
// ---------------------------------------------------------------------------
// perf_event_counters
//
// Event-statistics unit that sits beside the pipeline. One counter per event
// channel plus a free-running cycle counter (index NUM_EVENTS). Each counter
// either saturates at all-ones or wraps to zero, and records a sticky
// overflow flag. Counting freezes once the processor halts so final totals
// can be read back at leisure.
//
// Ports
//   clk       rising-edge clock for all state
//   rst       synchronous, active-high reset
//   en        global count enable (cycle counter included)
//   event_in  per-channel event strobes, one count per high cycle
//   halt      processor halted; moves the unit to FROZEN
//   clear     soft clear of counters/flags, returns to RUN
//   rd_en     read request
//   rd_sel    0..NUM_EVENTS-1 event counter, NUM_EVENTS cycle counter
//   rd_data   registered read data
//   rd_valid  one-cycle pulse qualifying rd_data
//   ovf       sticky overflow flags, bit NUM_EVENTS = cycle counter
//   frozen    high while counting is stopped after halt
//
// Read handshake: rd_en has no back-pressure. A request sampled at edge N
// returns the value held just before edge N, with rd_valid high for exactly
// the cycle after edge N. rst or clear at edge N cancels that request.
// ---------------------------------------------------------------------------
module perf_event_counters #(
    parameter int NUM_EVENTS = 6,
    parameter int CNT_WIDTH  = 32,
    parameter int SATURATE   = 1,
    parameter int SEL_W      = $clog2(NUM_EVENTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NUM_EVENTS-1:0] event_in,
    input  logic                  halt,
    input  logic                  clear,
    input  logic                  rd_en,
    input  logic [SEL_W-1:0]      rd_sel,
    output logic [CNT_WIDTH-1:0]  rd_data,
    output logic                  rd_valid,
    output logic [NUM_EVENTS:0]   ovf,
    output logic                  frozen
);

    localparam int NUM_CNT = NUM_EVENTS + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] cnt [NUM_CNT];
    logic [NUM_CNT-1:0]   inc;
    logic [CNT_WIDTH-1:0] sel_data;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // clear wins over halt; halt is honoured even with en low.
    always_comb begin
        state_next = state;
        inc        = '0;
        if (clear) begin
            state_next = ST_RUN;
        end else if (state == ST_RUN) begin
            if (en) begin
                // Cycle counter sits in the top bit alongside the events.
                inc = {1'b1, event_in};
            end
            if (halt) begin
                state_next = ST_FROZEN;
            end
        end
    end

    assign frozen = (state == ST_FROZEN);

    // ---------------- counters ----------------
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt[i] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (inc[i]) begin
                    if (&cnt[i]) begin
                        ovf[i] <= 1'b1;
                        cnt[i] <= (SATURATE != 0) ? cnt[i] : '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_ONE;
                    end
                end
            end
        end
    end

    // ---------------- read port ----------------
    // Out-of-range selects fall through to zero.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (int'(rd_sel) == i) begin
                sel_data = cnt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (clear) begin
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            rd_data  <= sel_data;
            rd_valid <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule
